control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 65 ++++++
 rtl/control_sequencer_opcode_decoder.sv | 24 ++
 rtl/control_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state encoding, opcodes,
// IR field positions and the bundle of control strobes.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RA_MSB     = 26;
  localparam int RA_LSB     = 23;
  localparam int RB_MSB     = 22;
  localparam int RB_LSB     = 19;
  localparam int RC_MSB     = 18;
  localparam int RC_LSB     = 15;

  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_SHR   = 5'b00111;
  localparam logic [4:0] OP_SHRA  = 5'b01000;
  localparam logic [4:0] OP_SHL   = 5'b01001;
  localparam logic [4:0] OP_ROR   = 5'b01010;
  localparam logic [4:0] OP_ROL   = 5'b01011;
  localparam logic [4:0] OP_NOP   = 5'b11010;
  localparam logic [4:0] OP_HALT  = 5'b11011;
  localparam logic [4:0] ALU_NONE = 5'b11111;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       mar_in;
    logic       z_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       inc_pc;
    logic       read;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       done;
    logic       illegal;
    logic [4:0] alu_op;
  } ctrl_t;

  // The ALU opcodes form one contiguous range, add through rol.
  function automatic logic is_alu_opcode(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Combinational opcode classifier: splits IR into ALU / nop / halt / illegal.
module opcode_decoder
  import control_sequencer_pkg::*;
(
  input  logic [31:0] IR,
  output logic        is_alu,
  output logic        is_nop,
  output logic        is_halt,
  output logic        is_illegal
);

  logic [4:0] opcode;
  logic       unused_fields;

  assign opcode        = IR[OPCODE_MSB:OPCODE_LSB];
  // Register fields are consumed by the select-and-encode logic outside.
  assign unused_fields = ^IR[RA_MSB:0];

  assign is_alu     = is_alu_opcode(opcode);
  assign is_nop     = (opcode == OP_NOP);
  assign is_halt    = (opcode == OP_HALT);
  assign is_illegal = !(is_alu || is_nop || is_halt);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: T0-T2 fetch, T3-T5 execute, Moore
// strobes decoded from the registered state and the opcode in IR.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  ALU_op,
  output logic        Done,
  output logic        Illegal
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl;
  logic   is_alu;
  logic   is_nop;
  logic   is_halt;
  logic   is_illegal;

  opcode_decoder u_opcode_decoder (
    .IR         (IR),
    .is_alu     (is_alu),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_NONE;
    state_next  = state_reg;
    case (state_reg)
      S_IDLE: if (Run) state_next = S_T0;
      S_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
        state_next  = S_T1;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        state_next    = S_T2;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        state_next   = S_T3;
      end
      S_T3: begin
        if (is_alu) begin
          ctrl.grb   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.y_in  = 1'b1;
          state_next = S_T4;
        end else if (is_halt) begin
          ctrl.done  = 1'b1;
          state_next = S_HALT;
        end else begin
          // nop completes here; an unsupported opcode is flagged and skipped.
          ctrl.done    = is_nop;
          ctrl.illegal = is_illegal;
          state_next   = Run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        ctrl.grc    = 1'b1;
        ctrl.r_out  = 1'b1;
        ctrl.z_in   = 1'b1;
        ctrl.alu_op = IR[OPCODE_MSB:OPCODE_LSB];
        state_next  = S_T5;
      end
      S_T5: begin
        ctrl.zlow_out = 1'b1;
        ctrl.gra      = 1'b1;
        ctrl.r_in     = 1'b1;
        ctrl.done     = 1'b1;
        state_next    = Run ? S_T0 : S_IDLE;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes are forced quiet while reset is held, even before the first edge.
  assign PCout   = Resetn & ctrl.pc_out;
  assign Zlowout = Resetn & ctrl.zlow_out;
  assign MDRout  = Resetn & ctrl.mdr_out;
  assign MARin   = Resetn & ctrl.mar_in;
  assign Zin     = Resetn & ctrl.z_in;
  assign PCin    = Resetn & ctrl.pc_in;
  assign MDRin   = Resetn & ctrl.mdr_in;
  assign IRin    = Resetn & ctrl.ir_in;
  assign Yin     = Resetn & ctrl.y_in;
  assign IncPC   = Resetn & ctrl.inc_pc;
  assign Read    = Resetn & ctrl.read;
  assign Gra     = Resetn & ctrl.gra;
  assign Grb     = Resetn & ctrl.grb;
  assign Grc     = Resetn & ctrl.grc;
  assign Rin     = Resetn & ctrl.r_in;
  assign Rout    = Resetn & ctrl.r_out;
  assign Done    = Resetn & ctrl.done;
  assign Illegal = Resetn & ctrl.illegal;
  assign ALU_op  = Resetn ? ctrl.alu_op : ALU_NONE;

endmodule
